// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel (AR/R) between the icache and
// dcache refill ports. One transaction in flight at a time: IDLE -> AR -> R.
// Default grant policy is dcache-first with an icache starvation guard.
// Build option: define RD_ARB_RR_EN for round-robin arbitration on contention
// (the starvation counter is then not built).
module axi_rd_arbiter #(
    parameter logic [3:0] ICACHE_ID  = 4'd0,
    parameter logic [3:0] DCACHE_ID  = 4'd1,
    parameter int         STARVE_MAX = 4,
    parameter int         LINE_BEATS = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ic_rd_req,
    input  logic [2:0]  ic_rd_type,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_rdy,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,
    output logic [31:0] ic_ret_data,
    input  logic        dc_rd_req,
    input  logic [2:0]  dc_rd_type,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,
    output logic [31:0] dc_ret_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        busy,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t      state;
    logic        cur_ic;      // granted requester is the icache
    logic [7:0]  beat_cnt;
    logic        pick_ic;
    logic [2:0]  sel_type;
    logic [31:0] sel_addr;
    logic [7:0]  len_n;
    logic [2:0]  size_n;
    logic        type_bad;
    logic        beat_hit;
    logic        beat_bad_id;
    logic        at_len;
    logic        beat_end;

    assign arburst = 2'b01;

`ifdef RD_ARB_RR_EN
    logic last_ic;            // last grant went to the icache

    // Round robin on contention: the side not granted last wins
    always_comb pick_ic = ic_rd_req & (~dc_rd_req | ~last_ic);
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    // dcache first, unless the icache has been passed over STARVE_MAX times
    always_comb pick_ic = ic_rd_req & (~dc_rd_req | (starve_cnt == SW'(STARVE_MAX)));
`endif

    assign sel_type = pick_ic ? ic_rd_type : dc_rd_type;
    assign sel_addr = pick_ic ? ic_rd_addr : dc_rd_addr;

    // Request type -> burst length/size; unknown types degrade to a word read
    always_comb begin
        len_n    = 8'd0;
        size_n   = 3'd2;
        type_bad = 1'b0;
        case (sel_type)
            3'd4:             len_n    = 8'(LINE_BEATS - 1);
            3'd0, 3'd1, 3'd2: size_n   = sel_type;
            default:          type_bad = 1'b1;
        endcase
    end

    // R-phase beat classification; arid holds the granted id during the burst
    always_comb begin
        beat_hit    = (state == R) & rvalid & (rid == arid);
        beat_bad_id = (state == R) & rvalid & (rid != arid);
        at_len      = (beat_cnt == arlen);
        beat_end    = beat_hit & (rlast | at_len);
    end

    // Return path is combinational from the R channel to the granted port only
    always_comb begin
        ic_ret_valid = beat_hit & cur_ic;
        dc_ret_valid = beat_hit & ~cur_ic;
        ic_ret_last  = beat_end & cur_ic;
        dc_ret_last  = beat_end & ~cur_ic;
        ic_ret_data  = ic_ret_valid ? rdata : 32'd0;
        dc_ret_data  = dc_ret_valid ? rdata : 32'd0;
    end

    // Main FSM with registered AR-side outputs, grant pulses and error flag
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            cur_ic    <= 1'b0;
            beat_cnt  <= 8'd0;
            ic_rd_rdy <= 1'b0;
            dc_rd_rdy <= 1'b0;
            arid      <= 4'd0;
            araddr    <= 32'd0;
            arlen     <= 8'd0;
            arsize    <= 3'd0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
`ifdef RD_ARB_RR_EN
            last_ic   <= 1'b1;
`else
            starve_cnt <= '0;
`endif
        end else begin
            ic_rd_rdy <= 1'b0;
            dc_rd_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_rd_req | dc_rd_req) begin
                        state     <= AR;
                        arvalid   <= 1'b1;
                        busy      <= 1'b1;
                        cur_ic    <= pick_ic;
                        arid      <= pick_ic ? ICACHE_ID : DCACHE_ID;
                        araddr    <= sel_addr;
                        arlen     <= len_n;
                        arsize    <= size_n;
                        beat_cnt  <= 8'd0;
                        ic_rd_rdy <= pick_ic;
                        dc_rd_rdy <= ~pick_ic;
                        if (type_bad) proto_err <= 1'b1;
`ifdef RD_ARB_RR_EN
                        last_ic   <= pick_ic;
`endif
                    end
`ifndef RD_ARB_RR_EN
                    if (!ic_rd_req)
                        starve_cnt <= '0;
                    else if (pick_ic)
                        starve_cnt <= '0;
                    else if (starve_cnt != SW'(STARVE_MAX))
                        starve_cnt <= starve_cnt + SW'(1);
`endif
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (beat_bad_id) proto_err <= 1'b1;
                    if (beat_hit) beat_cnt <= beat_cnt + 8'd1;
                    if (beat_end) begin
                        state  <= IDLE;
                        rready <= 1'b0;
                        busy   <= 1'b0;
                        // early rlast, or length reached without rlast
                        if (rlast != at_len) proto_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed tests, a transaction-level model of the
// expected AR stream and return routing, and literal checks pinning the model.
module tb_axi_rd_arbiter;
    localparam logic [3:0] ICID = 4'd0;
    localparam logic [3:0] DCID = 4'd1;

    logic aclk = 1'b0, aresetn = 1'b0;
    logic ic_rd_req = 0, dc_rd_req = 0;
    logic [2:0] ic_rd_type = 0, dc_rd_type = 0;
    logic [31:0] ic_rd_addr = 0, dc_rd_addr = 0;
    logic ic_rd_rdy, ic_ret_valid, ic_ret_last, dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [31:0] ic_ret_data, dc_ret_data, araddr;
    logic [3:0] arid;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic arvalid, rready, busy, proto_err;
    logic arready = 1'b1, rlast = 1'b0, rvalid = 1'b0;
    logic [3:0] rid = 4'd0;
    logic [31:0] rdata = 32'd0;

    axi_rd_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
        .dc_ret_data(dc_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic        bad;
    } txn_t;

    int vectors = 0, errs = 0;
    txn_t exp_q[$];
    int grants[$];            // 0 = icache, 1 = dcache, in grant order
    bit auto_en = 1'b1;
    int cnt_icv = 0, cnt_icl = 0, cnt_dcv = 0;
    logic [7:0] hs_len = 8'd0;

    // model state: the transaction currently returning data
    bit m_act = 0, m_perr = 0, hit, endb;
    txn_t m;
    int m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected AR fields from the request type, straight from the mapping rules
    function automatic txn_t mk(input logic [3:0] id, input logic [31:0] a, input logic [2:0] t);
        txn_t x;
        x.id = id; x.addr = a; x.len = 8'd0; x.size = 3'd2; x.bad = 1'b0;
        if (t == 3'd4) x.len = 8'd15;
        else if (t <= 3'd2) x.size = t;
        else x.bad = 1'b1;
        return x;
    endfunction

    // Compare process: every cycle out of reset
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_act = 0; m_perr = 0; m_cnt = 0;
            exp_q.delete();
        end else begin
            hit  = m_act && rvalid && (rid == m.id);
            endb = hit && (rlast || (m_cnt == int'(m.len)));
            chk("ic_ret_valid", ic_ret_valid, hit && (m.id == ICID));
            chk("dc_ret_valid", dc_ret_valid, hit && (m.id == DCID));
            chk("ic_ret_last", ic_ret_last, endb && (m.id == ICID));
            chk("dc_ret_last", dc_ret_last, endb && (m.id == DCID));
            chk("rready", rready, m_act);
            chk("rdy_onehot", ic_rd_rdy & dc_rd_rdy, 0);
            if (hit) chk("ret_data", (m.id == ICID) ? ic_ret_data : dc_ret_data, rdata);
            if (m_act) chk("proto_err", proto_err, m_perr);
            if (ic_rd_rdy) grants.push_back(0);
            if (dc_rd_rdy) grants.push_back(1);
            if (ic_ret_valid) cnt_icv++;
            if (ic_ret_last) cnt_icl++;
            if (dc_ret_valid) cnt_dcv++;
            // advance model
            if (m_act && rvalid && rid != m.id) m_perr = 1;
            if (endb) begin
                if (rlast != (m_cnt == int'(m.len))) m_perr = 1;
                m_act = 0;
            end
            if (hit) m_cnt++;
            if (arvalid && arready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ar", 1, 0);
                end else begin
                    m = exp_q.pop_front();
                    chk("arid", arid, m.id);
                    chk("araddr", araddr, m.addr);
                    chk("arlen", arlen, m.len);
                    chk("arsize", arsize, m.size);
                    chk("arburst", arburst, 2'b01);
                    hs_len = arlen;
                    m_act = 1; m_cnt = 0;
                    if (m.bad) m_perr = 1;
                end
            end
        end
    end

    // Auto AXI slave: answers each AR with arlen+1 beats, data = beat index
    initial begin
        int n;
        logic [3:0] sid;
        forever begin
            @(negedge aclk);
            if (auto_en && aresetn && arvalid && arready) begin
                n = int'(arlen) + 1; sid = arid;
                @(posedge aclk); #1;
                for (int b = 0; b < n; b++) begin
                    rvalid = 1; rid = sid; rdata = 32'(b); rlast = (b == n - 1);
                    @(posedge aclk); #1;
                end
                rvalid = 0; rlast = 0;
            end
        end
    end

    task automatic req(input bit ic, input logic [2:0] t, input logic [31:0] a);
        bit ok = 0;
        @(posedge aclk); #1;
        if (ic) begin ic_rd_req = 1; ic_rd_type = t; ic_rd_addr = a; end
        else    begin dc_rd_req = 1; dc_rd_type = t; dc_rd_addr = a; end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge aclk);
            ok = ic ? ic_rd_rdy : dc_rd_rdy;
        end
        if (!ok) chk("rdy_timeout", 0, 1);
        @(posedge aclk); #1;
        if (ic) ic_rd_req = 0; else dc_rd_req = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge aclk);
            ok = !busy;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_r();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge aclk);
            ok = rready;
        end
        if (!ok) chk("r_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge aclk); #1 aresetn = 0;
        @(posedge aclk); #1 aresetn = 1;
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] d, input bit last);
        @(posedge aclk); #1;
        rvalid = 1; rid = id; rdata = d; rlast = last;
    endtask

    initial begin
        int exp_g[5];
        bit ok;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_ic_rdy", ic_rd_rdy, 0);
        @(posedge aclk); #1 aresetn = 1;

        // single icache line
        exp_q.push_back(mk(ICID, 32'h1FC0_0000, 3'd4));
        req(1, 3'd4, 32'h1FC0_0000);
        wait_idle();
        chk("line_ic_valid_cnt", cnt_icv, 16);
        chk("line_ic_last_cnt", cnt_icl, 1);
        chk("line_dc_valid_cnt", cnt_dcv, 0);
        chk("line_arlen", hs_len, 8'd15);
        chk("line_proto_err", proto_err, 0);

        // contention: both held high
`ifdef RD_ARB_RR_EN
        exp_g = '{1, 0, 1, 0, 1};
`else
        exp_g = '{1, 1, 1, 1, 0};
`endif
        foreach (exp_g[i])
            exp_q.push_back(exp_g[i] == 1 ? mk(DCID, 32'h8000_0010, 3'd2)
                                           : mk(ICID, 32'h1000_0000, 3'd4));
        grants.delete();
        @(posedge aclk); #1;
        ic_rd_req = 1; ic_rd_type = 3'd4; ic_rd_addr = 32'h1000_0000;
        dc_rd_req = 1; dc_rd_type = 3'd2; dc_rd_addr = 32'h8000_0010;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge aclk);
            ok = (grants.size() >= 5);
        end
        if (!ok) chk("contention_timeout", 0, 1);
        @(posedge aclk); #1 ic_rd_req = 0; dc_rd_req = 0;
        wait_idle();
        chk("grant_count", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            chk($sformatf("grant_%0d", i), grants[i], exp_g[i]);

        // arready stall
        @(posedge aclk); #1 arready = 0;
        exp_q.push_back(mk(DCID, 32'h2000_0002, 3'd1));
        req(0, 3'd1, 32'h2000_0002);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_arvalid", arvalid, 1);
            chk("stall_araddr", araddr, 32'h2000_0002);
            chk("stall_arid", arid, DCID);
            chk("stall_arlen", arlen, 0);
            chk("stall_busy", busy, 1);
        end
        @(posedge aclk); #1 arready = 1;
        wait_idle();

        // wrong-id beat on a dcache word read
        auto_en = 0;
        chk("wid_pre_perr", proto_err, 0);
        exp_q.push_back(mk(DCID, 32'h4000_0000, 3'd2));
        req(0, 3'd2, 32'h4000_0000);
        wait_r();
        beat(ICID, 32'hDEAD_0000, 0);
        @(negedge aclk);
        chk("wid_drop", dc_ret_valid, 0);
        beat(DCID, 32'hBEEF_0001, 1);
        @(negedge aclk);
        chk("wid_fwd", dc_ret_valid, 1);
        chk("wid_last", dc_ret_last, 1);
        chk("wid_data", dc_ret_data, 32'hBEEF_0001);
        chk("wid_perr", proto_err, 1);
        @(posedge aclk); #1 rvalid = 0; rlast = 0;
        wait_idle();

        // early rlast on beat 8 of a line
        do_reset();
        exp_q.push_back(mk(ICID, 32'h5000_0000, 3'd4));
        req(1, 3'd4, 32'h5000_0000);
        wait_r();
        for (int b = 0; b < 8; b++) begin
            beat(ICID, 32'h100 + 32'(b), b == 7);
            @(negedge aclk);
            if (b == 7) chk("early_last", ic_ret_last, 1);
        end
        @(posedge aclk); #1 rvalid = 0; rlast = 0;
        @(negedge aclk);
        chk("early_busy", busy, 0);
        chk("early_perr", proto_err, 1);

        // unknown type -> word read plus error
        do_reset();
        auto_en = 1;
        exp_q.push_back(mk(DCID, 32'h3000_0000, 3'd3));
        req(0, 3'd3, 32'h3000_0000);
        wait_idle();
        chk("type3_perr", proto_err, 1);

        // reset at beat 5 of a line
        do_reset();
        auto_en = 0;
        exp_q.push_back(mk(ICID, 32'h6000_0000, 3'd4));
        req(1, 3'd4, 32'h6000_0000);
        wait_r();
        for (int b = 0; b < 4; b++) beat(ICID, 32'(b), 0);
        beat(ICID, 32'd4, 0);
        aresetn = 0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("mid_rst_ic_valid", ic_ret_valid, 0);
        chk("mid_rst_ic_last", ic_ret_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_araddr", araddr, 0);
        chk("mid_rst_arlen", arlen, 0);
        chk("mid_rst_perr", proto_err, 0);
        @(posedge aclk); #1 rvalid = 0; aresetn = 1;
        auto_en = 1;
        cnt_dcv = 0;
        exp_q.push_back(mk(DCID, 32'h7000_0000, 3'd2));
        req(0, 3'd2, 32'h7000_0000);
        wait_idle();
        chk("post_rst_dc_beats", cnt_dcv, 1);
        chk("post_rst_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
